// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path: FSM state, FIFO word
// layout, scan-code prefixes and the frame parity helper.
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// First-word-fall-through FIFO of ps2_event_t. The head word is held in a
// register that is 0 whenever the FIFO is empty.
module ps2_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  ps2_event_t             push_data,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output ps2_event_t             head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    ps2_event_t    mem_r [DEPTH];
    ps2_event_t    head_r;
    ps2_event_t    head_nxt_s;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] rd_ptr_nxt_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic [CW-1:0] remain_s;
    logic          valid_r;
    logic          full_s;
    logic          do_push_s;
    logic          do_pop_s;

    // Occupancy bookkeeping and look-ahead of the next head word.
    always_comb begin
        full_s       = (count_r == FULL_CNT);
        do_pop_s     = pop & valid_r;
        do_push_s    = push & (~full_s | do_pop_s);
        rd_ptr_nxt_s = do_pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
        remain_s     = count_r - CW'(do_pop_s);
        count_nxt_s  = remain_s + CW'(do_push_s);
        // With nothing left after the pop, the incoming word becomes the head directly.
        if (count_nxt_s == '0) begin
            head_nxt_s = '0;
        end else if (remain_s == '0) begin
            head_nxt_s = push_data;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Storage, pointers, count and registered head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            head_r   <= '0;
            valid_r  <= 1'b0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            head_r   <= head_nxt_s;
            valid_r  <= (count_nxt_s != '0);
        end
    end

    assign full  = full_s;
    assign empty = ~valid_r;
    assign head  = head_r;
    assign count = count_r;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver in the system clock domain: synchronise, glitch-filter,
// decode 11-bit frames, fold E0/F0 prefixes and buffer events in a FIFO.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN    = 8,
    parameter int TIMEOUT_CYC   = 20000,
    parameter int FIFO_DEPTH    = 16,
    parameter int PREFIX_DECODE = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ps2_clk_i,
    input  logic                        ps2_data_i,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [7:0]                  rd_code,
    output logic                        rd_ext,
    output logic                        rd_brk,
    output logic                        parity_err,
    output logic                        frame_err,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0] FILT_LAST = 8'(FILTER_LEN - 1);
    localparam logic PREFIX_EN = (PREFIX_DECODE != 0);

    logic [1:0]    clk_sync_r;
    logic [1:0]    data_sync_r;
    logic [7:0]    filt_cnt_r;
    logic          filt_clk_r;
    logic          fall_r;
    ps2_state_t    state_r;
    ps2_state_t    state_nxt_s;
    logic [7:0]    shreg_r;
    logic [2:0]    bitcnt_r;
    logic          par_r;
    logic [TW-1:0] tmo_cnt_r;
    logic          ext_pend_r;
    logic          brk_pend_r;
    logic          parity_err_r;
    logic          frame_err_r;
    logic          overflow_r;
    logic          data_s;
    logic          tmo_hit_s;
    logic          commit_s;
    logic          perr_s;
    logic          ferr_s;
    logic          is_prefix_s;
    logic          push_s;
    ps2_event_t    push_ev_s;
    ps2_event_t    head_s;
    logic          full_s;
    logic          empty_s;

    assign data_s    = data_sync_r[1];
    assign tmo_hit_s = (state_r != IDLE) && !fall_r && (tmo_cnt_r == TMO_LAST);

    // Two-flop synchronisers for both pins; idle bus level is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_r  <= 2'b11;
            data_sync_r <= 2'b11;
        end else begin
            clk_sync_r  <= {clk_sync_r[0], ps2_clk_i};
            data_sync_r <= {data_sync_r[0], ps2_data_i};
        end
    end

    // Glitch filter on the clock line plus the registered falling-edge pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_cnt_r <= 8'd0;
            filt_clk_r <= 1'b1;
            fall_r     <= 1'b0;
        end else begin
            fall_r <= filt_clk_r && !clk_sync_r[1] && (filt_cnt_r == FILT_LAST);
            if (clk_sync_r[1] == filt_clk_r) begin
                filt_cnt_r <= 8'd0;
            end else if (filt_cnt_r == FILT_LAST) begin
                filt_clk_r <= clk_sync_r[1];
                filt_cnt_r <= 8'd0;
            end else begin
                filt_cnt_r <= filt_cnt_r + 8'd1;
            end
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Frame FSM next-state logic; a timeout overrides any other transition.
    always_comb begin
        state_nxt_s = state_r;
        if (tmo_hit_s) begin
            state_nxt_s = IDLE;
        end else if (fall_r) begin
            case (state_r)
                IDLE:    state_nxt_s = data_s ? IDLE : DATA;
                DATA:    state_nxt_s = (bitcnt_r == 3'd7) ? PARITY : DATA;
                PARITY:  state_nxt_s = STOP;
                STOP:    state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Frame FSM outputs: verdict on the stop-bit edge, or a timeout abort.
    always_comb begin
        commit_s = 1'b0;
        perr_s   = 1'b0;
        ferr_s   = 1'b0;
        if (tmo_hit_s) begin
            ferr_s = 1'b1;
        end else if ((state_r == STOP) && fall_r) begin
            if (!odd_parity_ok(shreg_r, par_r)) begin
                perr_s = 1'b1;
            end else if (!data_s) begin
                ferr_s = 1'b1;
            end else begin
                commit_s = 1'b1;
            end
        end else begin
            commit_s = 1'b0;
        end
    end

    // Shift register, bit counter, parity capture and inter-edge timeout counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_r   <= 8'd0;
            bitcnt_r  <= 3'd0;
            par_r     <= 1'b0;
            tmo_cnt_r <= '0;
        end else begin
            case (state_r)
                IDLE: bitcnt_r <= 3'd0;
                DATA: begin
                    if (fall_r) begin
                        shreg_r  <= {data_s, shreg_r[7:1]};
                        bitcnt_r <= bitcnt_r + 3'd1;
                    end
                end
                PARITY: begin
                    if (fall_r) begin
                        par_r <= data_s;
                    end
                end
                default: bitcnt_r <= bitcnt_r;
            endcase
            if ((state_r == IDLE) || fall_r || tmo_hit_s) begin
                tmo_cnt_r <= '0;
            end else begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
            end
        end
    end

    // Prefix folding: E0/F0 are absorbed into flags that ride on the next real code.
    always_comb begin
        is_prefix_s = PREFIX_EN && ((shreg_r == PS2_PREFIX_EXT) || (shreg_r == PS2_PREFIX_BRK));
        push_s      = commit_s && !is_prefix_s;
        push_ev_s   = '{ext: ext_pend_r & PREFIX_EN, brk: brk_pend_r & PREFIX_EN, code: shreg_r};
    end

    // Pending prefix flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_pend_r <= 1'b0;
            brk_pend_r <= 1'b0;
        end else if (perr_s || ferr_s || push_s) begin
            ext_pend_r <= 1'b0;
            brk_pend_r <= 1'b0;
        end else if (commit_s && is_prefix_s) begin
            if (shreg_r == PS2_PREFIX_EXT) begin
                ext_pend_r <= 1'b1;
            end else begin
                brk_pend_r <= 1'b1;
            end
        end
    end

    // Registered status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            parity_err_r <= perr_s;
            frame_err_r  <= ferr_s;
            overflow_r   <= push_s && full_s && !(rd_ready && !empty_s);
        end
    end

    ps2_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_ev_s),
        .pop       (rd_ready),
        .full      (full_s),
        .empty     (empty_s),
        .head      (head_s),
        .count     (fifo_count)
    );

    assign rd_valid   = ~empty_s;
    assign rd_code    = head_s.code;
    assign rd_ext     = head_s.ext;
    assign rd_brk     = head_s.brk;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign overflow   = overflow_r;

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- Next-generation PS/2 keyboard receiver that runs entirely in the FPGA system clock domain.
- Oversamples the device clock and data lines, filters glitches and decodes 11-bit frames (start, 8 data LSB-first, odd parity, stop).
- Optionally folds E0/F0 prefixes into extended/break flags.
- Buffers results in a parametrised first-word-fall-through FIFO with a valid/ready read port for the downstream key-event logic.

Parameters:
- FILTER_LEN, 8: consecutive identical samples required before the filtered ps2 clock changes state (2..255).
- TIMEOUT_CYC, 20000: system clocks without a filtered falling edge before an in-progress frame is aborted.
- FIFO_DEPTH, 16: entries in the output FIFO; power of 2, at least 2.
- PREFIX_DECODE, 1: 1 = absorb E0/F0 into flags; 0 = push every byte raw.

Ports:
- clk  in  1  system clock; the only clock in the block.
- reset  in  1  asynchronous, active-high reset.
- ps2_clk_i  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data_i  in  1  raw PS/2 data pin, asynchronous.
- rd_valid  out  1  FIFO non-empty.
- rd_ready  in  1  consumer accepts the head entry.
- rd_code  out  8  head scan code; 0 when empty.
- rd_ext  out  1  head entry was preceded by E0; 0 when empty.
- rd_brk  out  1  head entry was preceded by F0 (key release); 0 when empty.
- parity_err  out  1  one-cycle pulse: frame rejected for bad parity.
- frame_err  out  1  one-cycle pulse: bad stop bit or timeout abort.
- overflow  out  1  one-cycle pulse: byte dropped because FIFO full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (asynchronous assert, synchronous release in clk) clears everything: all outputs 0, FSM IDLE, synchronisers to 1, filtered clk to 1, FIFO empty, prefix flags 0, timeout counter 0.
- Both pins pass through 2-flop synchronisers.
- Glitch filter: filt_clk takes the synchronised value only after FILTER_LEN consecutive equal samples.
- fall is a one-cycle pulse when filt_clk goes 1->0.
- ps2_data is sampled from its synchroniser output in the fall cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0 -> DATA, bitcnt=0. On fall with data=1, stay in IDLE with no error.
  - DATA: on each fall, shreg <= {data, shreg[7:1]}, bitcnt++. After the 8th bit -> PARITY.
  - PARITY: on fall, store the parity bit -> STOP.
  - STOP: on fall, always -> IDLE.
    - Odd parity over the 9 bits fails: parity_err pulse, no push.
    - Parity passes, stop=0: frame_err pulse, no push.
    - Parity passes, stop=1: byte committed to the decoder.
- Timeout: the counter runs in every non-IDLE state and clears on each fall. Reaching TIMEOUT_CYC-1 forces IDLE and pulses frame_err. In IDLE the counter is held at 0.
- Prefix decoder with PREFIX_DECODE=1:
  - Byte E0 sets ext_pend and is not pushed.
  - Byte F0 sets brk_pend and is not pushed.
  - Any other byte is pushed with {ext_pend, brk_pend}, then both pend flags clear.
  - parity_err or frame_err also clears both pend flags.
- Prefix decoder with PREFIX_DECODE=0: every committed byte is pushed with ext=brk=0.
- FIFO and timing:
  - The push occurs in the same cycle as the stop-bit fall.
  - With the FIFO empty, rd_valid=1 and data is valid in the next cycle.
  - Pop occurs when rd_valid & rd_ready.
  - Push while full without a pop: byte dropped, overflow pulse, contents unchanged.
  - Push and pop in the same cycle while full: both happen and the count is unchanged.
  - Push and pop in the same cycle while empty is not possible, because rd_valid=0.
  - Pointers wrap modulo FIFO_DEPTH; the count saturates at FIFO_DEPTH.
- Error pulses never overlap a push in the same cycle.

Decomposition:
- Package ps2_pkg holds:
  - PS2_PREFIX_EXT = 8'hE0 and PS2_PREFIX_BRK = 8'hF0.
  - Typedef ps2_state_t: enum IDLE/DATA/PARITY/STOP.
  - Typedef ps2_event_t: packed struct {ext, brk, code[7:0]}, 10 bits, used as the FIFO word.
- One sub-module, ps2_fifo: parametrised FWFT FIFO of ps2_event_t with push/full/pop/empty/count.

Test Plan:
- Frame 0x1C (data LSB-first 0,0,1,1,1,0,0,0; parity 0; stop 1), rd_ready=1 -> one entry code=0x1C, ext=0, brk=0; rd_valid for exactly 1 cycle; no error pulses.
- Sequence E0, F0, 0x74 with PREFIX_DECODE=1 -> a single entry code=0x74, ext=1, brk=1. Same sequence with PREFIX_DECODE=0 -> three entries E0, F0, 74, all flags 0.
- Frame 0x1C with parity=1 -> parity_err pulse, fifo_count stays 0. Next good frame 0x1B is pushed normally.
- Start and 3 data bits, then ps2_clk held high for TIMEOUT_CYC cycles -> frame_err pulse, FSM IDLE. A following good 0x2A is received correctly.
- FIFO_DEPTH=4, rd_ready=0, six frames 0x01..0x06 -> fifo_count=4, overflow pulses twice. Draining returns 01, 02, 03, 04.
- Glitch test: ps2_clk low pulses of FILTER_LEN-1 cycles mid-frame -> no extra bit shifted, frame decodes correctly. Assert reset mid-frame -> rd_valid=0, count=0, and the next full frame decodes cleanly.
